// File: rtl/max7219_cmd_feeder.sv
// MAX7219 command feeder: shadow digit registers, power-up init sequence,
// change-driven register writes and optional periodic full refresh.
//
// Ports:
//   clk, reset          clock / async active-high reset
//   wr_en, wr_digit,    host digit write (digit 0..7, code byte)
//   wr_data
//   intensity           desired brightness, sampled every cycle
//   cmd_valid/ready     handshake to the SPI serializer
//   cmd_addr, cmd_data  MAX7219 register address / data
//   init_done           init sequence fully accepted
module max7219_cmd_feeder #(
    parameter logic [7:0]  DECODE_MODE    = 8'hFF,
    parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
    parameter logic [23:0] REFRESH_PERIOD = 24'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_digit,
    input  logic [7:0] wr_data,
    input  logic [3:0] intensity,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       init_done
);

    typedef enum logic [2:0] {
        S_INIT0,
        S_INIT1,
        S_INIT2,
        S_INIT3,
        S_INIT4,
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    state_t      init_next;
    logic [7:0]  digit_q [8];
    logic [7:0]  dirty_q, dirty_d;
    logic        int_pend_q, int_pend_d;
    logic [3:0]  last_int_q, last_int_d;
    logic [23:0] ref_cnt_q, ref_cnt_d;
    logic        valid_d, init_done_d;
    logic [7:0]  addr_d, data_d;
    logic [7:0]  init_addr, init_data;
    logic        int_clr;
    logic [7:0]  dig_clr;
    logic [2:0]  sel_idx;
    logic        sel_hit;
    logic        ref_en, ref_tc;

    // Fixed init register writes; intensity is taken live at issue time.
    always_comb begin
        init_addr = 8'h00;
        init_data = 8'h00;
        init_next = S_GAP;
        unique case (state_q)
            S_INIT0: begin
                init_addr = 8'h0F;
                init_data = 8'h00;
                init_next = S_INIT1;
            end
            S_INIT1: begin
                init_addr = 8'h0C;
                init_data = 8'h01;
                init_next = S_INIT2;
            end
            S_INIT2: begin
                init_addr = 8'h0B;
                init_data = {5'b0, SCAN_LIMIT};
                init_next = S_INIT3;
            end
            S_INIT3: begin
                init_addr = 8'h0A;
                init_data = {4'b0, intensity};
                init_next = S_INIT4;
            end
            S_INIT4: begin
                init_addr = 8'h09;
                init_data = DECODE_MODE;
                init_next = S_GAP;
            end
            default: ;
        endcase
    end

    // Lowest-index dirty digit wins.
    always_comb begin
        sel_idx = 3'd0;
        sel_hit = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (dirty_q[i]) begin
                sel_idx = i[2:0];
                sel_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = cmd_valid;
        addr_d      = cmd_addr;
        data_d      = cmd_data;
        init_done_d = init_done;
        last_int_d  = last_int_q;
        int_clr     = 1'b0;
        dig_clr     = 8'h00;
        unique case (state_q)
            S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4: begin
                if (!cmd_valid) begin
                    valid_d = 1'b1;
                    addr_d  = init_addr;
                    data_d  = init_data;
                    if (state_q == S_INIT3)
                        last_int_d = intensity;
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = init_next;
                    if (state_q == S_INIT4)
                        init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (int_pend_q) begin
                    addr_d     = 8'h0A;
                    data_d     = {4'b0, intensity};
                    last_int_d = intensity;
                    int_clr    = 1'b1;
                    state_d    = S_SEND;
                end else if (sel_hit) begin
                    addr_d  = {5'b0, sel_idx} + 8'd1;
                    data_d  = digit_q[sel_idx];
                    dig_clr = 8'h01 << sel_idx;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!cmd_valid) begin
                    valid_d = 1'b1;
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: state_d = S_IDLE;
        endcase
    end

    assign ref_en = (REFRESH_PERIOD != 24'd0) && init_done;
    assign ref_tc = ref_en && (ref_cnt_q == REFRESH_PERIOD - 24'd1);

    // Set terms are ORed after the clear so a coincident write or
    // refresh keeps the digit pending.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        if (ref_en)
            ref_cnt_d = ref_tc ? 24'd0 : ref_cnt_q + 24'd1;
        dirty_d = dirty_q & ~dig_clr;
        if (wr_en)
            dirty_d = dirty_d | (8'h01 << wr_digit);
        if (ref_tc)
            dirty_d = 8'hFF;
        int_pend_d = int_pend_q & ~int_clr;
        if (init_done && (intensity != last_int_q) && !int_clr)
            int_pend_d = 1'b1;
        if (ref_tc)
            int_pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT0;
            cmd_valid  <= 1'b0;
            cmd_addr   <= 8'h00;
            cmd_data   <= 8'h00;
            init_done  <= 1'b0;
            dirty_q    <= 8'hFF;
            int_pend_q <= 1'b0;
            last_int_q <= 4'h0;
            ref_cnt_q  <= 24'd0;
        end else begin
            state_q    <= state_d;
            cmd_valid  <= valid_d;
            cmd_addr   <= addr_d;
            cmd_data   <= data_d;
            init_done  <= init_done_d;
            dirty_q    <= dirty_d;
            int_pend_q <= int_pend_d;
            last_int_q <= last_int_d;
            ref_cnt_q  <= ref_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                digit_q[i] <= 8'h00;
        end else if (wr_en) begin
            digit_q[wr_digit] <= wr_data;
        end
    end

endmodule
